mem_loader: RTL and testbench

Boot-time program loader for the MEH16 core: the write-side initiator of the main RAM port. It accepts a byte stream, assembles big-endian 16-bit words and writes them into RAM from address 0 using the RAM's mar/ram_load/bus interface. It then reads the image back through ram_en/out and checks a 16-bit checksum. It holds the CPU in reset-like stall (cpu_hold) for the whole session.

---
 rtl/meh16_pkg.sv | 37 +++
 rtl/mem_loader_if.sv | 30 +++
 rtl/mem_loader_csum16.sv | 29 ++
 rtl/mem_loader.sv | 246 ++++++++++++++++++++++++
 tb/tb_mem_loader.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/meh16_pkg.sv
`default_nettype none
// ============================================================================
// Module      : meh16_pkg
// Description : Shared widths, loader state encoding and error codes for the
//               MEH16 boot loader.
// Revision    : 1.0
// ============================================================================
package meh16_pkg;

    localparam int ADDR_W    = 12;
    localparam int DATA_W    = 16;
    localparam int RAM_DEPTH = 4096;
    localparam int WORDS_W   = 13;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_LEN_HI  = 4'd1,
        S_LEN_LO  = 4'd2,
        S_DATA_HI = 4'd3,
        S_DATA_LO = 4'd4,
        S_WRITE   = 4'd5,
        S_CS_HI   = 4'd6,
        S_CS_LO   = 4'd7,
        S_VRD     = 4'd8,
        S_VWAIT   = 4'd9,
        S_CHECK   = 4'd10,
        S_DONE    = 4'd11,
        S_ERR     = 4'd12
    } ld_state_t;

    localparam logic [1:0] c_err_none    = 2'b00;
    localparam logic [1:0] c_err_bad_len = 2'b01;
    localparam logic [1:0] c_err_rx_cs   = 2'b10;
    localparam logic [1:0] c_err_rd_cs   = 2'b11;

endpackage
`default_nettype wire

// File: rtl/mem_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_loader_if
// Description : Byte-stream receive port and main-RAM port of the loader.
// Revision    : 1.0
// ============================================================================
interface mem_loader_if #(
    parameter int ADDR_W = meh16_pkg::ADDR_W,
    parameter int DATA_W = meh16_pkg::DATA_W
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              ram_en;
    logic              ram_load;
    logic [ADDR_W-1:0] mar;
    logic [DATA_W-1:0] bus;
    logic [DATA_W-1:0] ram_out;

    modport master (
        input  rx_data, rx_valid, ram_out,
        output rx_ready, ram_en, ram_load, mar, bus
    );

    modport slave (
        output rx_data, rx_valid, ram_out,
        input  rx_ready, ram_en, ram_load, mar, bus
    );
endinterface
`default_nettype wire

// File: rtl/mem_loader_csum16.sv
`default_nettype none
// ============================================================================
// Module      : csum16
// Description : Clearable 16-bit running sum, wraps modulo 2^16.
// Revision    : 1.0
// ============================================================================
module csum16 import meh16_pkg::*; (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              i_clr,
    input  wire logic              i_add,
    input  wire logic [DATA_W-1:0] i_data,
    output logic      [DATA_W-1:0] o_sum
);
    logic [DATA_W-1:0] r_sum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sum <= '0;
        end else if (i_clr) begin
            r_sum <= '0;
        end else if (i_add) begin
            r_sum <= r_sum + i_data;
        end
    end

    assign o_sum = r_sum;
endmodule
`default_nettype wire

// File: rtl/mem_loader.sv
`default_nettype none
// ============================================================================
// Module      : mem_loader
// Description : Receives a length/data/checksum byte frame, writes it to RAM
//               from address 0, reads it back and verifies the checksum.
// Revision    : 1.0
// ============================================================================
module mem_loader import meh16_pkg::*; (
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire logic               start,
    mem_loader_if.master            mif,
    output logic                    busy,
    output logic                    cpu_hold,
    output logic                    done,
    output logic                    error,
    output logic [1:0]              err_code,
    output logic [WORDS_W-1:0]      words
);
    ld_state_t          r_state;
    ld_state_t          w_next;
    logic [7:0]         r_hi;
    logic [WORDS_W-1:0] r_len;
    logic [DATA_W-1:0]  r_word;
    logic [DATA_W-1:0]  r_cs;
    logic [ADDR_W-1:0]  r_vaddr;
    logic               r_busy;
    logic               r_hold;
    logic               r_done;
    logic               r_error;
    logic [1:0]         r_code;
    logic [WORDS_W-1:0] r_words;

    logic               w_rx_ready;
    logic               w_ram_en;
    logic               w_ram_load;
    logic [ADDR_W-1:0]  w_mar;
    logic [DATA_W-1:0]  w_bus;
    logic               w_clr;
    logic               w_rx_add;
    logic               w_rd_add;
    logic               w_set_done;
    logic               w_set_err;
    logic [1:0]         w_code;
    logic [DATA_W-1:0]  w_rx_sum;
    logic [DATA_W-1:0]  w_rd_sum;

    logic               w_accept;
    logic [DATA_W-1:0]  w_pair;
    logic               w_len_bad;
    logic               w_last_wr;
    logic               w_last_rd;

    assign w_accept  = mif.rx_valid && w_rx_ready;
    assign w_pair    = {r_hi, mif.rx_data};
    assign w_len_bad = (w_pair == '0) || (w_pair > 16'(RAM_DEPTH));
    assign w_last_wr = ((r_words + 13'd1) == r_len);
    assign w_last_rd = ({1'b0, r_vaddr} == (r_len - 13'd1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_rx_ready = 1'b0;
        w_ram_en   = 1'b0;
        w_ram_load = 1'b0;
        w_mar      = '0;
        w_bus      = '0;
        w_clr      = 1'b0;
        w_rx_add   = 1'b0;
        w_rd_add   = 1'b0;
        w_set_done = 1'b0;
        w_set_err  = 1'b0;
        w_code     = c_err_none;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_LEN_HI;
                    w_clr  = 1'b1;
                end
            end
            S_LEN_HI: begin
                w_rx_ready = 1'b1;
                if (mif.rx_valid) w_next = S_LEN_LO;
            end
            S_LEN_LO: begin
                w_rx_ready = 1'b1;
                if (mif.rx_valid) begin
                    if (w_len_bad) begin
                        w_next    = S_ERR;
                        w_set_err = 1'b1;
                        w_code    = c_err_bad_len;
                    end else begin
                        w_next = S_DATA_HI;
                    end
                end
            end
            S_DATA_HI: begin
                w_rx_ready = 1'b1;
                if (mif.rx_valid) w_next = S_DATA_LO;
            end
            S_DATA_LO: begin
                w_rx_ready = 1'b1;
                if (mif.rx_valid) w_next = S_WRITE;
            end
            S_WRITE: begin
                w_ram_load = 1'b1;
                w_mar      = r_words[ADDR_W-1:0];
                w_bus      = r_word;
                w_rx_add   = 1'b1;
                w_next     = w_last_wr ? S_CS_HI : S_DATA_HI;
            end
            S_CS_HI: begin
                w_rx_ready = 1'b1;
                if (mif.rx_valid) w_next = S_CS_LO;
            end
            S_CS_LO: begin
                w_rx_ready = 1'b1;
                if (mif.rx_valid) begin
                    if (w_rx_sum != w_pair) begin
                        w_next    = S_ERR;
                        w_set_err = 1'b1;
                        w_code    = c_err_rx_cs;
                    end else begin
                        w_next = S_VRD;
                    end
                end
            end
            S_VRD: begin
                w_ram_en = 1'b1;
                w_mar    = r_vaddr;
                w_next   = S_VWAIT;
            end
            S_VWAIT: begin
                w_rd_add = 1'b1;
                w_next   = w_last_rd ? S_CHECK : S_VRD;
            end
            S_CHECK: begin
                if (w_rd_sum == r_cs) begin
                    w_next     = S_DONE;
                    w_set_done = 1'b1;
                end else begin
                    w_next    = S_ERR;
                    w_set_err = 1'b1;
                    w_code    = c_err_rd_cs;
                end
            end
            S_DONE:  w_next = S_IDLE;
            S_ERR:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Status flags are sticky: only a new start or reset clears them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hi    <= '0;
            r_len   <= '0;
            r_word  <= '0;
            r_cs    <= '0;
            r_vaddr <= '0;
            r_busy  <= 1'b0;
            r_hold  <= 1'b0;
            r_done  <= 1'b0;
            r_error <= 1'b0;
            r_code  <= c_err_none;
            r_words <= '0;
        end else begin
            if (w_clr) begin
                r_busy  <= 1'b1;
                r_hold  <= 1'b1;
                r_done  <= 1'b0;
                r_error <= 1'b0;
                r_code  <= c_err_none;
                r_words <= '0;
                r_vaddr <= '0;
            end
            if (w_accept && (r_state == S_LEN_HI || r_state == S_DATA_HI || r_state == S_CS_HI)) begin
                r_hi <= mif.rx_data;
            end
            if (w_accept && r_state == S_LEN_LO && !w_len_bad) begin
                r_len <= w_pair[WORDS_W-1:0];
            end
            if (w_accept && r_state == S_DATA_LO) begin
                r_word <= w_pair;
            end
            if (w_accept && r_state == S_CS_LO) begin
                r_cs <= w_pair;
            end
            if (r_state == S_WRITE) begin
                r_words <= r_words + 13'd1;
            end
            if (r_state == S_VWAIT) begin
                r_vaddr <= r_vaddr + 12'd1;
            end
            if (w_set_done) begin
                r_done <= 1'b1;
                r_busy <= 1'b0;
                r_hold <= 1'b0;
            end
            if (w_set_err) begin
                r_error <= 1'b1;
                r_code  <= w_code;
                r_busy  <= 1'b0;
            end
        end
    end

    csum16 u_rx_sum (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_clr),
        .i_add  (w_rx_add),
        .i_data (r_word),
        .o_sum  (w_rx_sum)
    );

    csum16 u_rd_sum (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_clr),
        .i_add  (w_rd_add),
        .i_data (mif.ram_out),
        .o_sum  (w_rd_sum)
    );

    assign mif.rx_ready = w_rx_ready;
    assign mif.ram_en   = w_ram_en;
    assign mif.ram_load = w_ram_load;
    assign mif.mar      = w_mar;
    assign mif.bus      = w_bus;

    assign busy     = r_busy;
    assign cpu_hold = r_hold;
    assign done     = r_done;
    assign error    = r_error;
    assign err_code = r_code;
    assign words    = r_words;
endmodule
`default_nettype wire

// File: tb/tb_mem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_loader
// Description : Directed frames into mem_loader against a frame-level model
//               and a behavioural RAM with registered read.
// Revision    : 1.0
// ============================================================================
module tb_mem_loader;
    import meh16_pkg::*;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        start = 1'b0;
    logic        busy, cpu_hold, done, error;
    logic [1:0]  err_code;
    logic [12:0] words;

    mem_loader_if u_if ();

    mem_loader dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .mif      (u_if),
        .busy     (busy),
        .cpu_hold (cpu_hold),
        .done     (done),
        .error    (error),
        .err_code (err_code),
        .words    (words)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // RAM model, 1-cycle registered read; optional corruption of address 1
    logic [15:0] mem [0:4095];
    logic        corrupt_en = 1'b0;
    logic        mem_clear  = 1'b0;

    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 4096; i++) mem[i] <= 16'h0000;
        end else if (u_if.ram_load) begin
            mem[u_if.mar] <= (corrupt_en && u_if.mar == 12'd1) ? (u_if.bus ^ 16'h8000) : u_if.bus;
        end
        if (u_if.ram_en) u_if.ram_out <= mem[u_if.mar];
    end

    typedef struct {
        logic [11:0] a;
        logic [15:0] d;
    } wr_t;

    wr_t         exp_wr [$];
    wr_t         w_pop;
    logic [15:0] frame [0:4095];
    int          cyc    = 0;
    int          tot_wr = 0;
    int          tot_rd = 0;
    int          wr0, rd0;
    logic [12:0] exp_rd = '0;
    logic [11:0] last_wr = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Compare process: every RAM access against the expected write list and
    // the expected sequential readback addresses.
    always @(negedge clk) begin
        if (rst) begin
            exp_rd <= '0;
        end else begin
            if (u_if.ram_en || u_if.ram_load)
                check("en_load_exclusive", {31'b0, u_if.ram_en & u_if.ram_load}, 32'd0);
            if (u_if.ram_load) begin
                if (exp_wr.size() == 0) begin
                    check("unexpected_write", 32'd1, 32'd0);
                end else begin
                    w_pop = exp_wr.pop_front();
                    check("wr_addr", {20'b0, u_if.mar}, {20'b0, w_pop.a});
                    check("wr_data", {16'b0, u_if.bus}, {16'b0, w_pop.d});
                end
                last_wr <= u_if.mar;
                tot_wr  <= tot_wr + 1;
                exp_rd  <= '0;
            end
            if (u_if.ram_en) begin
                check("rd_addr", {20'b0, u_if.mar}, {20'b0, exp_rd[11:0]});
                exp_rd <= exp_rd + 13'd1;
                tot_rd <= tot_rd + 1;
            end
            if (u_if.rx_ready) check("rx_ready_when_busy", {31'b0, busy}, 32'd1);
        end
    end

    function automatic int pick_gap(input int m);
        return (m == 0) ? 0 : int'($urandom_range(0, m));
    endfunction

    task automatic send(input logic [7:0] b, input int gap);
        int t;
        t = 0;
        repeat (gap) @(negedge clk);
        u_if.rx_data  = b;
        u_if.rx_valid = 1'b1;
        while (!u_if.rx_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) check("rx_ready_timeout", 32'd0, 32'd1);
        @(negedge clk);
        u_if.rx_valid = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},     {31'b0, busy},          32'd0);
        check({tag, "_cpu_hold"}, {31'b0, cpu_hold},      32'd0);
        check({tag, "_done"},     {31'b0, done},          32'd0);
        check({tag, "_error"},    {31'b0, error},         32'd0);
        check({tag, "_err_code"}, {30'b0, err_code},      32'd0);
        check({tag, "_words"},    {19'b0, words},         32'd0);
        check({tag, "_rx_ready"}, {31'b0, u_if.rx_ready}, 32'd0);
        check({tag, "_ram_en"},   {31'b0, u_if.ram_en},   32'd0);
        check({tag, "_ram_load"}, {31'b0, u_if.ram_load}, 32'd0);
        check({tag, "_mar"},      {20'b0, u_if.mar},      32'd0);
        check({tag, "_bus"},      {16'b0, u_if.bus},      32'd0);
    endtask

    task automatic run_session(input logic [15:0] len, input logic [15:0] cs, input int gap_max,
                               input int abort_at, output int cycles);
        int  s, t;
        bit  valid;
        valid  = (len != 16'd0) && (len <= 16'd4096);
        cycles = 0;
        @(negedge clk);
        wr0   = tot_wr;
        rd0   = tot_rd;
        start = 1'b1;
        s     = cyc;
        if (valid)
            for (int i = 0; i < int'(len); i++) exp_wr.push_back('{a: 12'(i), d: frame[i]});
        @(negedge clk);
        start = 1'b0;
        send(len[15:8], pick_gap(gap_max));
        send(len[7:0],  pick_gap(gap_max));
        if (valid) begin
            for (int i = 0; i < int'(len); i++) begin
                send(frame[i][15:8], pick_gap(gap_max));
                if (i == abort_at) begin
                    check("abort_words_before_rst", {19'b0, words}, 32'(abort_at));
                    rst = 1'b1;
                    #1;
                    check_all_zero("abort");
                    @(negedge clk);
                    rst = 1'b0;
                    exp_wr.delete();
                    return;
                end
                send(frame[i][7:0], pick_gap(gap_max));
            end
            send(cs[15:8], pick_gap(gap_max));
            send(cs[7:0],  pick_gap(gap_max));
        end
        t = 0;
        while (!(done || error) && t < 60000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 60000) check("session_timeout", 32'd0, 32'd1);
        cycles = cyc - s + 1;
    endtask

    // Frame-level expectation: length rule, receive checksum, readback checksum
    task automatic expect_result(input string tag, input logic [15:0] len, input logic [15:0] cs);
        bit          valid;
        logic [15:0] rx_sum, rb_sum;
        logic [1:0]  code;
        int          n;
        valid  = (len != 16'd0) && (len <= 16'd4096);
        n      = valid ? int'(len) : 0;
        rx_sum = '0;
        rb_sum = '0;
        for (int i = 0; i < n; i++) begin
            rx_sum = rx_sum + frame[i];
            rb_sum = rb_sum + mem[i];
        end
        if (!valid)            code = 2'b01;
        else if (rx_sum != cs) code = 2'b10;
        else if (rb_sum != cs) code = 2'b11;
        else                   code = 2'b00;
        check({tag, "_done"},     {31'b0, done},     {31'b0, code == 2'b00});
        check({tag, "_error"},    {31'b0, error},    {31'b0, code != 2'b00});
        check({tag, "_err_code"}, {30'b0, err_code}, {30'b0, code});
        check({tag, "_words"},    {19'b0, words},    32'(n));
        check({tag, "_busy"},     {31'b0, busy},     32'd0);
        check({tag, "_cpu_hold"}, {31'b0, cpu_hold}, {31'b0, code != 2'b00});
        check({tag, "_writes"},   32'(tot_wr - wr0), 32'(n));
        check({tag, "_reads"},    32'(tot_rd - rd0), (code == 2'b00 || code == 2'b11) ? 32'(n) : 32'd0);
        check({tag, "_pending"},  32'(exp_wr.size()), 32'd0);
    endtask

    task automatic clear_mem();
        @(negedge clk);
        mem_clear = 1'b1;
        @(negedge clk);
        mem_clear = 1'b0;
    endtask

    int          cycles;
    logic [15:0] cs5;

    initial begin
        u_if.rx_data  = 8'h00;
        u_if.rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        clear_mem();

        // Three words at full rate
        frame[0] = 16'h1234; frame[1] = 16'hABCD; frame[2] = 16'h0001;
        run_session(16'd3, 16'hBE02, 0, -1, cycles);
        expect_result("t1", 16'd3, 16'hBE02);
        check("t1_cycles", 32'(cycles), 32'd22);
        check("t1_mem0", {16'b0, mem[0]}, 32'h1234);
        check("t1_mem1", {16'b0, mem[1]}, 32'hABCD);
        check("t1_mem2", {16'b0, mem[2]}, 32'h0001);
        check("t1_done_lit", {31'b0, done}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        check("t1_done_sticky", {31'b0, done}, 32'd1);

        // Bad lengths
        run_session(16'd0, 16'h0000, 0, -1, cycles);
        expect_result("t2_zero", 16'd0, 16'h0000);
        check("t2_code_lit", {30'b0, err_code}, 32'd1);
        run_session(16'h1001, 16'h0000, 0, -1, cycles);
        expect_result("t2_big", 16'h1001, 16'h0000);

        // Checksum wrap, then receive checksum mismatch
        frame[0] = 16'hFFFF; frame[1] = 16'h0001;
        clear_mem();
        run_session(16'd2, 16'h0000, 0, -1, cycles);
        expect_result("t3a", 16'd2, 16'h0000);
        check("t3a_done_lit", {31'b0, done}, 32'd1);
        clear_mem();
        run_session(16'd2, 16'h0001, 0, -1, cycles);
        expect_result("t3b", 16'd2, 16'h0001);
        check("t3b_code_lit", {30'b0, err_code}, 32'd2);
        check("t3b_mem0", {16'b0, mem[0]}, 32'hFFFF);
        check("t3b_mem1", {16'b0, mem[1]}, 32'h0001);

        // Readback mismatch from a corrupted RAM word
        frame[0] = 16'h1111; frame[1] = 16'h2222;
        corrupt_en = 1'b1;
        run_session(16'd2, 16'h3333, 0, -1, cycles);
        corrupt_en = 1'b0;
        expect_result("t4", 16'd2, 16'h3333);
        check("t4_code_lit", {30'b0, err_code}, 32'd3);

        // Reset during DATA_LO of word 5, then a clean session
        for (int i = 0; i < 8; i++) frame[i] = 16'(16'h0100 * i + 16'h0011);
        run_session(16'd8, 16'h0000, 0, 4, cycles);
        frame[0] = 16'h1234; frame[1] = 16'hABCD; frame[2] = 16'h0001;
        run_session(16'd3, 16'hBE02, 0, -1, cycles);
        expect_result("t6", 16'd3, 16'hBE02);
        check("t6_cycles", 32'(cycles), 32'd22);

        // Full 4096-word image with random receive gaps
        cs5 = '0;
        for (int i = 0; i < 4096; i++) begin
            frame[i] = 16'(i * 40503 + 7);
            cs5      = cs5 + frame[i];
        end
        run_session(16'd4096, cs5, 2, -1, cycles);
        expect_result("t5", 16'd4096, cs5);
        check("t5_last_mar", {20'b0, last_wr}, 32'h0FFF);
        check("t5_words_lit", {19'b0, words}, 32'h1000);
        check("t5_done_lit", {31'b0, done}, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
